// File: rtl/ecc_scrub_ctrl.sv
// Background SECDED scrubber: walks the address space in idle host slots,
// writes back corrected single-bit errors and logs error addresses in a FIFO.
module ecc_scrub_ctrl #(
  parameter int AW        = 14,
  parameter int DW        = 64,
  parameter int RD_LAT    = 1,
  parameter int INTERVAL  = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scrub_en,
  input  logic          host_req,
  input  logic          host_wr,
  input  logic [AW-1:0] host_addr,
  output logic          host_gnt,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          sb_correct,
  input  logic          db_detect,
  output logic          log_valid,
  output logic [AW-1:0] log_addr,
  output logic          log_type,
  input  logic          log_pop,
  output logic          log_ovf,
  output logic [15:0]   sb_cnt,
  output logic [15:0]   db_cnt,
  output logic          pass_done,
  output logic [2:0]    dbg_state_o
);

  localparam int GW = $clog2(INTERVAL + 1);
  localparam int LW = $clog2(RD_LAT + 1);
  localparam int PW = $clog2(LOG_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GAP  = 3'd1,
    S_READ = 3'd2,
    S_RESP = 3'd3,
    S_WB   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          sb_f_q, sb_f_d;
  logic          db_f_q, db_f_d;
  logic          haz_q, haz_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [15:0]   sb_cnt_q, db_cnt_q;
  logic          ovf_q;

  logic          ren, wen, advance, push, push_type, sb_inc, db_inc;
  logic          host_hit;

  logic [AW:0]   log_mem_q [LOG_DEPTH];
  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic          fifo_full, fifo_empty, do_push, do_pop;

  assign host_hit = host_req & host_wr & (host_addr == addr_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    gap_d     = gap_q;
    lat_d     = lat_q;
    sb_f_d    = sb_f_q;
    db_f_d    = db_f_q;
    haz_d     = haz_q;
    wdata_d   = wdata_q;
    ren       = 1'b0;
    wen       = 1'b0;
    advance   = 1'b0;
    push      = 1'b0;
    push_type = 1'b0;
    sb_inc    = 1'b0;
    db_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scrub_en) begin
          state_d = S_GAP;
          gap_d   = GW'(INTERVAL);
        end
      end
      S_GAP: begin
        gap_d = gap_q - 1'b1;
        if (!scrub_en) begin
          state_d = S_IDLE;
        end else if (gap_q <= GW'(1)) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (!host_req) begin
          ren     = 1'b1;
          lat_d   = LW'(RD_LAT);
          haz_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        haz_d = haz_q | host_hit;
        if (lat_q != '0) begin
          // Decoder outputs are valid in the cycle RD_LAT after the read issue.
          lat_d = lat_q - 1'b1;
          if (lat_q == LW'(1)) begin
            sb_f_d = sb_correct;
            db_f_d = db_detect;
            if (sb_correct && !db_detect) wdata_d = mem_rdata;
          end
        end else if (db_f_q) begin
          push      = 1'b1;
          push_type = 1'b1;
          db_inc    = 1'b1;
          advance   = 1'b1;
        end else if (sb_f_q) begin
          push    = 1'b1;
          sb_inc  = 1'b1;
          state_d = S_WB;
        end else begin
          advance = 1'b1;
        end
      end
      S_WB: begin
        haz_d = haz_q | host_hit;
        // A host write to this address since the read makes our data stale.
        if (haz_q) begin
          advance = 1'b1;
        end else if (!host_req) begin
          wen     = 1'b1;
          advance = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      addr_d  = addr_q + 1'b1;
      gap_d   = GW'(INTERVAL);
      state_d = scrub_en ? S_GAP : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      gap_q    <= '0;
      lat_q    <= '0;
      sb_f_q   <= 1'b0;
      db_f_q   <= 1'b0;
      haz_q    <= 1'b0;
      wdata_q  <= '0;
      sb_cnt_q <= '0;
      db_cnt_q <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
      lat_q   <= lat_d;
      sb_f_q  <= sb_f_d;
      db_f_q  <= db_f_d;
      haz_q   <= haz_d;
      wdata_q <= wdata_d;
      if (sb_inc && (sb_cnt_q != 16'hFFFF)) sb_cnt_q <= sb_cnt_q + 16'd1;
      if (db_inc && (db_cnt_q != 16'hFFFF)) db_cnt_q <= db_cnt_q + 16'd1;
      if (push && fifo_full && !do_pop) ovf_q <= 1'b1;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Log handshake: the head entry transfers on a cycle with log_valid=1 and log_pop=1.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_pop     = log_pop & ~fifo_empty;
  assign do_push    = push & (~fifo_full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) log_mem_q[wr_ptr_q[PW-1:0]] <= {addr_q, push_type};
  end

  assign log_valid   = ~fifo_empty;
  assign log_addr    = log_mem_q[rd_ptr_q[PW-1:0]][AW:1];
  assign log_type    = log_mem_q[rd_ptr_q[PW-1:0]][0];
  assign log_ovf     = ovf_q;
  assign sb_cnt      = sb_cnt_q;
  assign db_cnt      = db_cnt_q;
  assign mem_ren     = ren;
  assign mem_wen     = wen;
  assign host_gnt    = ~(ren | wen);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign pass_done   = advance & (&addr_q);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Scoreboard bench for ecc_scrub_ctrl: a decoder responder injects errors by
// address, a monitor checks every read, write-back and log pop against queues.
module tb_ecc_scrub_ctrl;
  localparam int AW = 4;
  localparam int DW = 64;
  localparam int RD_LAT = 1;
  localparam int INTERVAL = 4;
  localparam int LOG_DEPTH = 4;
  localparam logic [DW-1:0] D5 = 64'hDEAD_BEEF_0000_1234;
  localparam logic [DW-1:0] D9 = 64'h0123_4567_89AB_CDEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scrub_en = 1'b0;
  logic          host_req = 1'b0;
  logic          host_wr = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic          host_gnt, mem_ren, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          sb_correct = 1'b0;
  logic          db_detect = 1'b0;
  logic          log_valid, log_type, log_ovf, pass_done;
  logic [AW-1:0] log_addr;
  logic          log_pop = 1'b0;
  logic [15:0]   sb_cnt, db_cnt;
  logic [2:0]    dbg_state;

  ecc_scrub_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .INTERVAL(INTERVAL),
                   .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
    .host_gnt(host_gnt), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sb_correct(sb_correct), .db_detect(db_detect),
    .log_valid(log_valid), .log_addr(log_addr), .log_type(log_type),
    .log_pop(log_pop), .log_ovf(log_ovf), .sb_cnt(sb_cnt), .db_cnt(db_cnt),
    .pass_done(pass_done), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  initial begin
    #20000;
    $display("FAIL watchdog: cycle %0d reached time limit", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail = 0;
  int pass_cnt = 0;
  logic [32+AW-1:0]    exp_ren_q[$];   // {cycle, addr}
  logic [32+AW+DW-1:0] exp_wen_q[$];   // {cycle, addr, data}
  logic [AW:0]         exp_log_q[$];   // {addr, type}
  logic pop_en = 1'b0;
  logic pop_force = 1'b0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ren(input int c, input int a);
    exp_ren_q.push_back({32'(c), AW'(a)});
  endtask

  // Decoder model: flags and data for the address read RD_LAT=1 cycles earlier.
  always @(negedge clk) begin
    if (rst_n && mem_ren) begin
      logic [AW-1:0] ra;
      ra = mem_addr;
      @(posedge clk);
      #1;
      case (ra)
        4'd5:    begin sb_correct = 1'b1; db_detect = 1'b0; mem_rdata = D5; end
        4'd7:    begin sb_correct = 1'b1; db_detect = 1'b1; mem_rdata = 64'h7777; end
        4'd9:    begin sb_correct = 1'b1; db_detect = 1'b0; mem_rdata = D9; end
        4'd11, 4'd12, 4'd13, 4'd14, 4'd15:
                 begin sb_correct = 1'b0; db_detect = 1'b1; mem_rdata = 64'hBAD; end
        default: begin sb_correct = 1'b0; db_detect = 1'b0; mem_rdata = 64'h1111; end
      endcase
      @(posedge clk);
      #1;
      sb_correct = 1'b0;
      db_detect = 1'b0;
      mem_rdata = '0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    log_pop = pop_force | (pop_en & log_valid);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_ren) begin
        if (exp_ren_q.size() == 0) check("ren_unexpected", 64'(mem_ren), 64'd0);
        else begin
          logic [32+AW-1:0] e;
          e = exp_ren_q.pop_front();
          check("ren_addr", 64'(mem_addr), 64'(e[AW-1:0]));
          check("ren_cycle", 64'(cyc), 64'(e[32+AW-1:AW]));
          check("ren_gnt", 64'(host_gnt), 64'd0);
        end
      end
      if (mem_wen) begin
        if (exp_wen_q.size() == 0) check("wen_unexpected", 64'(mem_wen), 64'd0);
        else begin
          logic [32+AW+DW-1:0] e;
          e = exp_wen_q.pop_front();
          check("wen_addr", 64'(mem_addr), 64'(e[AW+DW-1:DW]));
          check("wen_data", mem_wdata, e[DW-1:0]);
          check("wen_cycle", 64'(cyc), 64'(e[32+AW+DW-1:AW+DW]));
        end
      end
      if (log_valid && log_pop) begin
        if (exp_log_q.size() == 0) check("log_unexpected", 64'(log_valid), 64'd0);
        else begin
          logic [AW:0] e;
          e = exp_log_q.pop_front();
          check("log_entry", 64'({log_addr, log_type}), 64'(e));
        end
      end
      if (host_req) check("host_gnt_when_req", 64'(host_gnt), 64'd1);
      if (pass_done) begin
        pass_cnt++;
        check("pass_done_cycle", 64'(cyc), 64'd117);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    // Expected reads: 7-cycle spacing, +3 for the host hold at addr 3,
    // +1 after each single-error address (WB cycle).
    push_ren(5, 0);   push_ren(12, 1);  push_ren(19, 2);  push_ren(29, 3);
    push_ren(36, 4);  push_ren(43, 5);  push_ren(51, 6);  push_ren(58, 7);
    push_ren(65, 8);  push_ren(72, 9);  push_ren(80, 10); push_ren(87, 11);
    push_ren(94, 12); push_ren(101, 13); push_ren(108, 14); push_ren(115, 15);
    push_ren(122, 0);
    exp_wen_q.push_back({32'd46, 4'd5, D5});
    exp_log_q.push_back({4'd5, 1'b0});
    exp_log_q.push_back({4'd7, 1'b1});
    exp_log_q.push_back({4'd9, 1'b0});
    exp_log_q.push_back({4'd11, 1'b1});
    exp_log_q.push_back({4'd12, 1'b1});
    exp_log_q.push_back({4'd13, 1'b1});
    exp_log_q.push_back({4'd14, 1'b1});

    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_ren", 64'(mem_ren), 64'd0);
    check("rst_wen", 64'(mem_wen), 64'd0);
    check("rst_gnt", 64'(host_gnt), 64'd1);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    check("rst_log_valid", 64'(log_valid), 64'd0);
    check("rst_ovf", 64'(log_ovf), 64'd0);
    check("rst_cnts", 64'({sb_cnt, db_cnt}), 64'd0);
    check("rst_pass_done", 64'(pass_done), 64'd0);
    scrub_en = 1'b1;
    rst_n = 1'b1;
    pop_en = 1'b1;

    // Host read holds the port for cycles 26..28 while the scrubber is in READ.
    wait_cyc(26);
    host_req = 1'b1; host_wr = 1'b0; host_addr = 4'd3;
    wait_cyc(29);
    host_req = 1'b0;

    // Host write to addr 9 during its RESP cycle cancels the write-back.
    wait_cyc(73);
    host_req = 1'b1; host_wr = 1'b1; host_addr = 4'd9;
    wait_cyc(74);
    host_req = 1'b0; host_wr = 1'b0;

    wait_cyc(80);
    pop_en = 1'b0;

    // Drop enable right after the second-pass read of addr 0 is issued.
    wait_cyc(123);
    scrub_en = 1'b0;

    wait_cyc(130);
    check("idle_after_disable", 64'(dbg_state), 64'd0);
    check("addr_resume_point", 64'(mem_addr), 64'd1);
    check("sb_cnt", 64'(sb_cnt), 64'd2);
    check("db_cnt", 64'(db_cnt), 64'd6);
    check("log_ovf", 64'(log_ovf), 64'd1);
    check("pass_done_count", 64'(pass_cnt), 64'd1);
    check("log_head_addr", 64'(log_addr), 64'd11);
    check("last_wdata", mem_wdata, D9);
    check("ren_queue_drained", 64'(exp_ren_q.size()), 64'd0);
    check("wen_queue_drained", 64'(exp_wen_q.size()), 64'd0);

    pop_en = 1'b1;
    wait_cyc(138);
    pop_en = 1'b0;
    check("log_queue_drained", 64'(exp_log_q.size()), 64'd0);
    check("log_empty", 64'(log_valid), 64'd0);

    pop_force = 1'b1;
    wait_cyc(141);
    pop_force = 1'b0;
    wait_cyc(142);
    check("pop_empty_ignored", 64'(log_valid), 64'd0);
    check("ovf_sticky", 64'(log_ovf), 64'd1);

    // Re-enable: resume at addr 1 with READ at cycle 147, then reset mid-strobe.
    scrub_en = 1'b1;
    wait_cyc(147);
    #2;
    check("resume_ren", 64'(mem_ren), 64'd1);
    check("resume_addr", 64'(mem_addr), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ren", 64'(mem_ren), 64'd0);
    check("async_rst_gnt", 64'(host_gnt), 64'd1);
    check("async_rst_addr", 64'(mem_addr), 64'd0);
    check("async_rst_cnt", 64'(sb_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
Background scrubber for the 64-bit SECDED-protected memory. It walks the whole address space with periodic reads, using memory slots the host leaves idle. It writes corrected data back on single-bit errors and logs error addresses into a small pop-able FIFO. Sits beside the ECC read path: consumes the decoder's corrected data, SB_CORRECT and DB_DETECT; drives the scrub side of the memory port mux.

Parameters:
AW, 14, memory address width
DW, 64, data width
RD_LAT, 1, cycles from mem_ren to valid mem_rdata/sb_correct/db_detect (>=1)
INTERVAL, 16, idle cycles between scrub accesses (>=1)
LOG_DEPTH, 4, error log FIFO entries (power of 2)

Ports:
clk  in  1  single clock; all state rises on posedge
rst_n  in  1  asynchronous active-low reset
scrub_en  in  1  enable scrubbing
host_req  in  1  host wants the memory port this cycle (host has priority)
host_wr  in  1  host access is a write (qualified by host_req)
host_addr  in  AW  host access address
host_gnt  out  1  host owns the port this cycle
mem_ren  out  1  scrub read strobe
mem_wen  out  1  scrub write-back strobe
mem_addr  out  AW  scrub address
mem_wdata  out  DW  corrected write-back data
mem_rdata  in  DW  corrected read data from ECC decoder
sb_correct  in  1  decoder single-error flag
db_detect  in  1  decoder multi-error flag
log_valid  out  1  log FIFO not empty
log_addr  out  AW  head entry address
log_type  out  1  head entry type: 0 single (corrected), 1 double (uncorrected)
log_pop  in  1  pop head entry when log_valid=1
log_ovf  out  1  sticky: error dropped because the log was full
sb_cnt  out  16  single-error count, saturates at 0xFFFF
db_cnt  out  16  double-error count, saturates at 0xFFFF
pass_done  out  1  one-cycle pulse when the address wraps to 0

Behaviour:
- Reset values: state IDLE, scrub address 0, all strobes 0, host_gnt 1, counters 0, FIFO empty, log_ovf 0, pass_done 0, mem_wdata 0.
- host_gnt = ~(mem_ren | mem_wen). Scrubber asserts a strobe only in a cycle where host_req=0, so the host is never refused.
- States: IDLE, GAP, READ, RESP, WB.
- IDLE: scrub_en=1 -> GAP. Gap counter loads INTERVAL.
- GAP: decrement each cycle. scrub_en=0 -> IDLE. Count expired -> READ.
- READ: if host_req=0, assert mem_ren with mem_addr=scrub address for one cycle, then go to RESP. Otherwise hold, with no timeout.
- RESP: the issue cycle is T; decoder outputs are sampled at cycle T+RD_LAT.
  - db_detect=1 (with any sb_correct): double error. Push {addr,1}, db_cnt++, advance.
  - sb_correct=1 and db_detect=0: single error. Capture mem_rdata into mem_wdata, push {addr,0}, sb_cnt++, then WB.
  - Neither flag: advance.
- Hazard: a host_req&host_wr to the scrub address in any cycle from T to the WB issue cycle sets a hazard flag. In WB with hazard set, skip the write and advance; the log entry and count are still kept.
- WB: if host_req=0 and no hazard, assert mem_wen for one cycle with mem_addr and mem_wdata, then advance. Otherwise hold.
- Advance: address +1, modulo 2^AW. Wrap from all-ones to 0 pulses pass_done in the same cycle as the increment. Next state is GAP if scrub_en=1, else IDLE.
- scrub_en drop outside GAP: finish the current address (including write-back), then go to IDLE. Address is preserved, so re-enable resumes.
- Log FIFO:
  - log_valid/log_addr/log_type show the head entry.
  - Push when full and no pop in the same cycle: drop the entry, set log_ovf (cleared only by reset).
  - Push and pop in the same cycle while full: both take effect, no overflow.
  - Pop when empty: ignored.
- Counters saturate at 0xFFFF and do not wrap.
- Reset mid-operation aborts any pending write-back immediately; strobes drop asynchronously.

Test Plan:
- INTERVAL=4, RD_LAT=1, scrub_en=1 from cycle 0, no errors, host idle -> mem_ren at addr 0 in cycle 5, addr 1 in cycle 12 (GAP 4 + READ + RESP + advance); host_gnt=0 only in mem_ren cycles.
- sb_correct=1, db_detect=0, mem_rdata=64'hDEAD_BEEF_0000_1234 on the addr 5 read -> next free cycle mem_wen=1, mem_addr=5, same data; sb_cnt=1; log {5,0}.
- sb_correct=1, db_detect=1 on addr 7 -> no mem_wen; db_cnt=1; log {7,1}.
- host_req held high for 3 cycles while in READ -> mem_ren delayed exactly 3 cycles; host_gnt=1 throughout.
- Single error at addr 9 with host write to addr 9 during RESP -> no mem_wen; sb_cnt increments; log {9,0}.
- AW=4, LOG_DEPTH=4, five double errors with no pops -> log_ovf=1, the first four addresses retained in order; pass_done pulses once after addr 15 -> 0.
